// File: rtl/plane_recip_div.sv
// Sequential reciprocal divider: recip = floor(2^NUMER_SHIFT / denom), saturated to all-ones,
// one restoring shift-subtract step per clk48 edge with a fixed start-to-done latency.
module plane_recip_div #(
  parameter int DENOM_W     = 10,
  parameter int RECIP_W     = 11,
  parameter int NUMER_SHIFT = 16
) (
  input  logic               clk48,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DENOM_W-1:0] denom,
  output logic [RECIP_W-1:0] recip,
  output logic               busy,
  output logic               done
);

  localparam int REM_W = DENOM_W + 1;
  localparam int K_W   = $clog2(RECIP_W);
  // Top numerator bits (NUMER_SHIFT..RECIP_W) as a value; any non-sat divisor exceeds it, so it is its own residue
  localparam logic [REM_W-1:0] SAT_LIM = REM_W'(2 ** (NUMER_SHIFT - RECIP_W));

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [DENOM_W-1:0]   d_r, d_s;
  logic [REM_W-1:0]     rem_r, rem_s;
  logic [RECIP_W-1:0]   quot_r, quot_s;
  logic [K_W-1:0]       k_r, k_s;
  logic                 sat_r, sat_s;
  logic                 load_r, load_s;
  logic [RECIP_W-1:0]   recip_r, recip_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;

  logic [REM_W:0]       trial_s;
  logic [REM_W:0]       diff_s;
  logic                 ge_s;

  // One restoring-division trial: shift in a numerator zero bit and compare against the divisor
  always_comb begin
    trial_s = {rem_r, 1'b0};
    diff_s  = trial_s - {2'b00, d_r};
    ge_s    = (trial_s >= {2'b00, d_r});
  end

  // Next-state and next-output logic; a start request overrides whatever is in progress
  always_comb begin
    state_s = state_r;
    d_s     = d_r;
    rem_s   = rem_r;
    quot_s  = quot_r;
    k_s     = k_r;
    sat_s   = sat_r;
    load_s  = load_r;
    recip_s = recip_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    if (start) begin
      d_s     = denom;
      rem_s   = {REM_W{1'b0}};
      quot_s  = {RECIP_W{1'b0}};
      sat_s   = ({1'b0, denom} <= SAT_LIM);
      k_s     = K_W'(RECIP_W - 1);
      load_s  = 1'b1;
      state_s = RUN;
      busy_s  = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          busy_s = 1'b0;
        end
        RUN: begin
          if (load_r) begin
            rem_s  = sat_r ? {REM_W{1'b0}} : SAT_LIM;
            load_s = 1'b0;
          end else begin
            rem_s         = REM_W'(ge_s ? diff_s : trial_s);
            quot_s[k_r]   = ge_s;
            if (k_r == K_W'(0)) begin
              recip_s = sat_r ? {RECIP_W{1'b1}} : quot_s;
              done_s  = 1'b1;
              busy_s  = 1'b0;
              state_s = IDLE;
            end else begin
              k_s = k_r - K_W'(1);
            end
          end
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      d_r     <= {DENOM_W{1'b0}};
      rem_r   <= {REM_W{1'b0}};
      quot_r  <= {RECIP_W{1'b0}};
      k_r     <= {K_W{1'b0}};
      sat_r   <= 1'b0;
      load_r  <= 1'b0;
      recip_r <= {RECIP_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      d_r     <= d_s;
      rem_r   <= rem_s;
      quot_r  <= quot_s;
      k_r     <= k_s;
      sat_r   <= sat_s;
      load_r  <= load_s;
      recip_r <= recip_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign recip = recip_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_plane_recip_div.sv
// Self-checking bench for plane_recip_div against an arithmetic reciprocal model.
module tb_plane_recip_div;

  logic        clk48;
  logic        rst_n;
  logic        start;
  logic [9:0]  denom;
  logic [10:0] recip;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  plane_recip_div dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .start (start),
    .denom (denom),
    .recip (recip),
    .busy  (busy),
    .done  (done)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  function automatic logic [10:0] ref_recip(input int d);
    int q;
    if (d == 0) return 11'd2047;
    q = 65536 / d;
    if (q > 2047) return 11'd2047;
    return q[10:0];
  endfunction

  // Issues start at the current negedge, then walks edges until done (bounded).
  // lat = edge index of done relative to the start edge (-1 if none).
  task automatic run_div(input logic [9:0] d, output int lat, output logic [10:0] val,
                         output int busy_cnt, output int n_done, output bit moved);
    logic [10:0] prior;
    prior = recip; lat = -1; val = 11'd0; busy_cnt = 0; n_done = 0; moved = 1'b0;
    start = 1'b1; denom = d;
    @(posedge clk48); @(negedge clk48);
    start = 1'b0; denom = 10'($urandom);
    for (int e = 0; e <= 30; e++) begin
      if (e > 0) begin @(posedge clk48); @(negedge clk48); end
      if (busy) busy_cnt++;
      if (done) begin n_done++; lat = e; val = recip; break; end
      if (recip !== prior) moved = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; denom = 10'd0;
    #2 rst_n = 1'b0;
    #3;
    tests++;
    if (recip !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got recip=%0d busy=%b done=%b expected 0/0/0", recip, busy, done);
    end
    repeat (3) @(negedge clk48);
    rst_n = 1'b1;
    repeat (4) @(negedge clk48);
    tests++;
    if (recip !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_idle: got recip=%0d busy=%b done=%b expected 0/0/0", recip, busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc, nd; logic [10:0] v; bit mv;
    run_div(10'd100, lat, v, bc, nd, mv);
    tests++; if (lat != 12) begin fails++; $display("FAIL basic_latency: got %0d expected 12", lat); end
    tests++; if (v !== 11'd655) begin fails++; $display("FAIL basic_recip: got %0d expected 655", v); end
    tests++; if (bc != 12) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 12", bc); end
    tests++; if (nd != 1 || mv) begin fails++; $display("FAIL basic_done_once: got done=%0d moved=%0d expected 1/0", nd, mv); end
    @(negedge clk48);
    tests++; if (done !== 1'b0 || busy !== 1'b0 || recip !== 11'd655) begin
      fails++; $display("FAIL basic_hold: got done=%b busy=%b recip=%0d expected 0/0/655", done, busy, recip);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, nd; logic [10:0] v; bit mv;
    run_div(10'd273, lat, v, bc, nd, mv);
    tests++; if (v !== 11'd240 || nd != 1 || lat != 12) begin
      fails++; $display("FAIL b2b_first: got recip=%0d done=%0d lat=%0d expected 240/1/12", v, nd, lat);
    end
    run_div(10'd1023, lat, v, bc, nd, mv);
    tests++; if (v !== 11'd64 || nd != 1 || lat != 12 || mv) begin
      fails++; $display("FAIL b2b_second: got recip=%0d done=%0d lat=%0d moved=%0d expected 64/1/12/0", v, nd, lat, mv);
    end
  endtask

  task automatic test_saturation();
    int lat, bc, nd; logic [10:0] v; bit mv;
    logic [9:0] ds [4];
    logic [10:0] ex [4];
    ds[0] = 10'd33; ex[0] = 11'd1985;
    ds[1] = 10'd32; ex[1] = 11'd2047;
    ds[2] = 10'd0;  ex[2] = 11'd2047;
    ds[3] = 10'd1;  ex[3] = 11'd2047;
    for (int i = 0; i < 4; i++) begin
      run_div(ds[i], lat, v, bc, nd, mv);
      tests++; if (v !== ex[i] || lat != 12 || nd != 1) begin
        fails++; $display("FAIL sat_d%0d: got recip=%0d lat=%0d expected %0d/12", ds[i], v, lat, ex[i]);
      end
      repeat (2) @(negedge clk48);
    end
  endtask

  task automatic test_restart();
    int lat, bc, nd; logic [10:0] v; bit mv; logic [10:0] prior; bit early;
    prior = recip; early = 1'b0;
    start = 1'b1; denom = 10'd100;
    @(posedge clk48); @(negedge clk48);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk48); @(negedge clk48);
      if (done || recip !== prior) early = 1'b1;
    end
    run_div(10'd200, lat, v, bc, nd, mv);
    tests++; if (early || mv) begin fails++; $display("FAIL restart_hold: got early=%0d moved=%0d expected 0/0", early, mv); end
    tests++; if (v !== 11'd327 || lat != 12 || nd != 1) begin
      fails++; $display("FAIL restart_result: got recip=%0d lat=%0d done=%0d expected 327/12/1", v, lat, nd);
    end
  endtask

  task automatic test_async_reset();
    bit bad;
    bad = 1'b0;
    start = 1'b1; denom = 10'd100;
    @(posedge clk48); @(negedge clk48);
    start = 1'b0;
    repeat (5) begin @(posedge clk48); @(negedge clk48); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (recip !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL async_reset: got recip=%0d busy=%b done=%b expected 0/0/0", recip, busy, done);
    end
    @(negedge clk48);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk48); @(negedge clk48);
      if (done || busy || recip !== 11'd0) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL async_release_quiet: got activity=1 expected 0"); end
  endtask

  task automatic test_sweep();
    int lat, bc, nd; logic [10:0] v; bit mv; bit unstable;
    logic [9:0] d;
    for (int i = 1; i <= 1073; i++) begin
      d = (i <= 1023) ? 10'(i) : 10'($urandom);
      run_div(d, lat, v, bc, nd, mv);
      tests++; if (v !== ref_recip(int'(d)) || lat != 12 || nd != 1 || mv || bc != 12) begin
        fails++; $display("FAIL sweep_d%0d: got recip=%0d lat=%0d done=%0d moved=%0d busy=%0d expected %0d/12/1/0/12",
                          d, v, lat, nd, mv, bc, ref_recip(int'(d)));
      end
      unstable = 1'b0;
      repeat (13 + ($urandom % 4)) begin
        @(posedge clk48); @(negedge clk48);
        if (done || recip !== v) unstable = 1'b1;
      end
      tests++; if (unstable) begin fails++; $display("FAIL sweep_gap_d%0d: got unstable=1 expected 0", d); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_restart();
    test_async_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
